// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the hardwired control unit: instruction opcodes,
// IR field geometry, the sequencer state encoding and small opcode-class
// helpers used by the control unit and its register-select decoder.
package cpu_pkg;

  localparam int GPR_N   = 16;
  localparam int IMM_MSB = 18;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHL  = 5'd8;
  localparam logic [4:0] OP_ROR  = 5'd9;
  localparam logic [4:0] OP_ROL  = 5'd10;
  localparam logic [4:0] OP_ADDI = 5'd11;
  localparam logic [4:0] OP_ANDI = 5'd12;
  localparam logic [4:0] OP_ORI  = 5'd13;
  localparam logic [4:0] OP_MUL  = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15;
  localparam logic [4:0] OP_NEG  = 5'd16;
  localparam logic [4:0] OP_NOT  = 5'd17;
  localparam logic [4:0] OP_BR   = 5'd18;
  localparam logic [4:0] OP_JR   = 5'd19;
  localparam logic [4:0] OP_JAL  = 5'd20;
  localparam logic [4:0] OP_IN   = 5'd21;
  localparam logic [4:0] OP_OUT  = 5'd22;
  localparam logic [4:0] OP_MFHI = 5'd23;
  localparam logic [4:0] OP_MFLO = 5'd24;
  localparam logic [4:0] OP_NOP  = 5'd25;
  localparam logic [4:0] OP_HALT = 5'd26;

  typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALTED} state_e;

  // Register-register ALU group (ADD..ROL)
  function automatic logic isAluRR(input logic [4:0] op);
    return (op >= OP_ADD) && (op <= OP_ROL);
  endfunction

  // Immediate ALU group (ADDI/ANDI/ORI)
  function automatic logic isAluImm(input logic [4:0] op);
    return (op >= OP_ADDI) && (op <= OP_ORI);
  endfunction

  // Memory-reference group (LD/LDI/ST) sharing the Rb+C address calculation
  function automatic logic isMemRef(input logic [4:0] op);
    return op <= OP_ST;
  endfunction

  function automatic logic isMulDiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic isNegNot(input logic [4:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  function automatic logic isLegal(input logic [4:0] op);
    return op <= OP_HALT;
  endfunction

  // The ALU only knows the register forms, so immediates map onto them
  function automatic logic [4:0] aluOp(input logic [4:0] op);
    case (op)
      OP_ADDI: return OP_ADD;
      OP_ANDI: return OP_AND;
      OP_ORI:  return OP_OR;
      default: return op;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_sel_enc_decode.sv
// sel_enc_decode
// Combinational register-select logic. Picks one of the Ra/Rb/Rc IR fields,
// turns it into one-hot GPR load/drive vectors and sign-extends the
// immediate field for the C bus source.
// Ports:
//   i_ir            in  27  IR[26:0] (Ra=[26:23], Rb=[22:19], Rc=[18:15], imm=[18:0])
//   i_gra/grb/grc   in  1   field select (priority Ra > Rb > Rc)
//   i_rin           in  1   load the selected GPR
//   i_rout          in  1   drive the selected GPR onto the bus
//   i_baout         in  1   base-address drive of the selected GPR
//   i_forceR15      in  1   redirect the load to R15 (link register)
//   o_enableIn      out 16  one-hot GPR load vector
//   o_outSel        out 16  one-hot GPR drive vector
//   o_cSignExtend   out 32  immediate sign-extended from bit 18
module sel_enc_decode
  import cpu_pkg::*;
(
  input  logic [26:0] i_ir,
  input  logic        i_gra,
  input  logic        i_grb,
  input  logic        i_grc,
  input  logic        i_rin,
  input  logic        i_rout,
  input  logic        i_baout,
  input  logic        i_forceR15,
  output logic [15:0] o_enableIn,
  output logic [15:0] o_outSel,
  output logic [31:0] o_cSignExtend
);

  logic [3:0]       w_sel;
  logic [GPR_N-1:0] w_oneHot;

  // Field select and one-hot expansion; BAout drives the base register
  // through the same vector, the datapath substitutes zero for R0.
  always_comb begin
    w_sel = 4'd0;
    if (i_gra)      w_sel = i_ir[26:23];
    else if (i_grb) w_sel = i_ir[22:19];
    else if (i_grc) w_sel = i_ir[18:15];
    w_oneHot = 16'(1) << w_sel;
    o_enableIn = '0;
    if (i_rin) o_enableIn = i_forceR15 ? 16'h8000 : w_oneHot;
    o_outSel = (i_rout || i_baout) ? w_oneHot : '0;
  end

  assign o_cSignExtend = {{(31 - IMM_MSB){i_ir[IMM_MSB]}}, i_ir[IMM_MSB:0]};

endmodule

// File: rtl/control_unit.sv
// control_unit
// Hardwired Moore sequencer: fetches through T0..T2, executes in T3..T7 and
// drives every datapath strobe from the registered step plus the current IR.
// Memory steps (fetch T1, LD T6, ST T7) are stretched by MEM_WAIT cycles.
// Optional build macro CTRL_ILLEGAL_TRAP_EN: an undefined opcode halts the
// sequencer and keeps 'illegal' high until clr; without it the opcode is
// treated as NOP with a one-cycle 'illegal' pulse.
// Ports:
//   clk, clr (sync, active-high), ir[31:0], con_ff           inputs
//   R0_15_enable_in/R0_15_out_in[15:0]                        GPR load/drive
//   PC/MAR/MDR/IR/Y/Z/HI/LO _enable                           register loads
//   PCout ZHighout ZLowout HIout LOout MDRout InPortout BAout Cout  bus sources
//   Read Write IncPC CON_enable OutPort_enable                misc strobes
//   C_sign_extend[31:0], opcode[OPC_W-1:0], run, illegal
module control_unit
  import cpu_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int OPC_W    = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      ir,
  input  logic             con_ff,
  output logic [15:0]      R0_15_enable_in,
  output logic [15:0]      R0_15_out_in,
  output logic             PC_enable,
  output logic             MAR_enable,
  output logic             MDR_enable,
  output logic             IR_enable,
  output logic             Y_enable,
  output logic             Z_enable,
  output logic             HI_enable,
  output logic             LO_enable,
  output logic             PCout,
  output logic             ZHighout,
  output logic             ZLowout,
  output logic             HIout,
  output logic             LOout,
  output logic             MDRout,
  output logic             InPortout,
  output logic             BAout,
  output logic             Cout,
  output logic             Read,
  output logic             Write,
  output logic             IncPC,
  output logic             CON_enable,
  output logic             OutPort_enable,
  output logic [31:0]      C_sign_extend,
  output logic [OPC_W-1:0] opcode,
  output logic             run,
  output logic             illegal
);

  state_e     r_state;
  logic [2:0] r_wait;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       r_illegal;
`endif

  logic [4:0] w_op;
  logic       w_legal, w_memStep, w_waitDone;
  logic       w_last3, w_last4, w_last5, w_last6;
  logic       w_gra, w_grb, w_grc, w_rin, w_rout, w_baout, w_forceR15;

  assign w_op       = ir[31:27];
  assign w_legal    = isLegal(w_op);
  assign w_waitDone = (r_wait == 3'd0);
  assign w_memStep  = (r_state == T1) || (r_state == T6 && w_op == OP_LD) ||
                      (r_state == T7 && w_op == OP_ST);
  assign w_last3    = (w_op == OP_JR) || (w_op == OP_IN) || (w_op == OP_OUT) ||
                      (w_op == OP_MFHI) || (w_op == OP_MFLO);
  assign w_last4    = isNegNot(w_op) || (w_op == OP_JAL);
  assign w_last5    = isAluRR(w_op) || isAluImm(w_op) || (w_op == OP_LDI);
  assign w_last6    = isMulDiv(w_op) || (w_op == OP_BR);

  // Step sequencer. A memory step holds while the wait counter drains;
  // every other cycle advances and reloads the counter, so it is already
  // primed with MEM_WAIT on the first cycle of whichever memory step follows.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= T0;
      r_wait  <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      r_illegal <= 1'b0;
`endif
    end else if (w_memStep && !w_waitDone) begin
      r_wait <= r_wait - 3'd1;
    end else begin
      r_wait <= 3'(MEM_WAIT);
      case (r_state)
        T0: r_state <= T1;
        T1: r_state <= T2;
        T2: begin
          if (w_op == OP_NOP)       r_state <= T0;
          else if (w_op == OP_HALT) r_state <= HALTED;
          else                      r_state <= T3;
        end
        T3: begin
          if (!w_legal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            r_state   <= HALTED;
            r_illegal <= 1'b1;
`else
            r_state <= T0;
`endif
          end else if (w_last3) r_state <= T0;
          else                  r_state <= T4;
        end
        T4: r_state <= w_last4 ? T0 : T5;
        T5: r_state <= w_last5 ? T0 : T6;
        T6: r_state <= w_last6 ? T0 : T7;
        T7: r_state <= T0;
        HALTED: r_state <= HALTED;
        default: r_state <= T0;
      endcase
    end
  end

  // Strobe decode from the current step and IR. While clr is held every
  // strobe is forced low so an abandoned instruction loads nothing.
  always_comb begin
    PC_enable = 1'b0; MAR_enable = 1'b0; MDR_enable = 1'b0; IR_enable = 1'b0;
    Y_enable = 1'b0; Z_enable = 1'b0; HI_enable = 1'b0; LO_enable = 1'b0;
    PCout = 1'b0; ZHighout = 1'b0; ZLowout = 1'b0; HIout = 1'b0; LOout = 1'b0;
    MDRout = 1'b0; InPortout = 1'b0; Cout = 1'b0;
    Read = 1'b0; Write = 1'b0; IncPC = 1'b0; CON_enable = 1'b0; OutPort_enable = 1'b0;
    w_gra = 1'b0; w_grb = 1'b0; w_grc = 1'b0; w_rin = 1'b0; w_rout = 1'b0;
    w_baout = 1'b0; w_forceR15 = 1'b0;
    opcode = '0;
    run = 1'b1;
    illegal = 1'b0;
    if (!clr) begin
      run = (r_state != HALTED);
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal = r_illegal;
`endif
      case (r_state)
        T0: begin PCout = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; Z_enable = 1'b1; end
        T1: begin ZLowout = 1'b1; PC_enable = 1'b1; Read = 1'b1; MDR_enable = w_waitDone; end
        T2: begin MDRout = 1'b1; IR_enable = 1'b1; end
        T3: begin
          if (!w_legal) illegal = 1'b1;
          else if (isAluRR(w_op) || isAluImm(w_op)) begin w_grb = 1'b1; w_rout = 1'b1; Y_enable = 1'b1; end
          else if (isNegNot(w_op)) begin
            w_grb = 1'b1; w_rout = 1'b1; Z_enable = 1'b1; opcode = OPC_W'(w_op);
          end
          else if (isMemRef(w_op)) begin w_grb = 1'b1; w_baout = 1'b1; Y_enable = 1'b1; end
          else if (isMulDiv(w_op)) begin w_gra = 1'b1; w_rout = 1'b1; Y_enable = 1'b1; end
          else begin
            case (w_op)
              OP_BR:   begin w_gra = 1'b1; w_rout = 1'b1; CON_enable = 1'b1; end
              OP_JR:   begin w_gra = 1'b1; w_rout = 1'b1; PC_enable = 1'b1; end
              OP_JAL:  begin PCout = 1'b1; w_rin = 1'b1; w_forceR15 = 1'b1; end
              OP_IN:   begin InPortout = 1'b1; w_gra = 1'b1; w_rin = 1'b1; end
              OP_OUT:  begin w_gra = 1'b1; w_rout = 1'b1; OutPort_enable = 1'b1; end
              OP_MFHI: begin HIout = 1'b1; w_gra = 1'b1; w_rin = 1'b1; end
              OP_MFLO: begin LOout = 1'b1; w_gra = 1'b1; w_rin = 1'b1; end
              default: ;
            endcase
          end
        end
        T4: begin
          if (isAluRR(w_op)) begin
            w_grc = 1'b1; w_rout = 1'b1; Z_enable = 1'b1; opcode = OPC_W'(w_op);
          end else if (isAluImm(w_op)) begin
            Cout = 1'b1; Z_enable = 1'b1; opcode = OPC_W'(aluOp(w_op));
          end else if (isNegNot(w_op)) begin
            ZLowout = 1'b1; w_gra = 1'b1; w_rin = 1'b1;
          end else if (isMemRef(w_op)) begin
            Cout = 1'b1; Z_enable = 1'b1; opcode = OPC_W'(OP_ADD);
          end else if (isMulDiv(w_op)) begin
            w_grb = 1'b1; w_rout = 1'b1; Z_enable = 1'b1; opcode = OPC_W'(w_op);
          end else if (w_op == OP_BR) begin
            PCout = 1'b1; Y_enable = 1'b1;
          end else if (w_op == OP_JAL) begin
            w_gra = 1'b1; w_rout = 1'b1; PC_enable = 1'b1;
          end
        end
        T5: begin
          if (w_last5) begin ZLowout = 1'b1; w_gra = 1'b1; w_rin = 1'b1; end
          else if (w_op == OP_LD || w_op == OP_ST) begin ZLowout = 1'b1; MAR_enable = 1'b1; end
          else if (isMulDiv(w_op)) begin ZLowout = 1'b1; LO_enable = 1'b1; end
          else if (w_op == OP_BR) begin Cout = 1'b1; Z_enable = 1'b1; opcode = OPC_W'(OP_ADD); end
        end
        T6: begin
          if (w_op == OP_LD) begin Read = 1'b1; MDR_enable = w_waitDone; end
          else if (w_op == OP_ST) begin w_gra = 1'b1; w_rout = 1'b1; MDR_enable = 1'b1; end
          else if (isMulDiv(w_op)) begin ZHighout = 1'b1; HI_enable = 1'b1; end
          else if (w_op == OP_BR) begin ZLowout = 1'b1; PC_enable = con_ff; end
        end
        T7: begin
          if (w_op == OP_LD) begin MDRout = 1'b1; w_gra = 1'b1; w_rin = 1'b1; end
          else if (w_op == OP_ST) Write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign BAout = w_baout;

  sel_enc_decode u_selEnc (
    .i_ir          (ir[26:0]),
    .i_gra         (w_gra),
    .i_grb         (w_grb),
    .i_grc         (w_grc),
    .i_rin         (w_rin),
    .i_rout        (w_rout),
    .i_baout       (w_baout),
    .i_forceR15    (w_forceR15),
    .o_enableIn    (R0_15_enable_in),
    .o_outSel      (R0_15_out_in),
    .o_cSignExtend (C_sign_extend)
  );

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
// Directed bench for control_unit. Instance 0 runs with MEM_WAIT=0 and walks
// through a sequence of instructions; instance 1 runs with MEM_WAIT=2 for the
// stretched LD memory steps. Expected strobes are written per step by hand.
module tb_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  clr, conFf;
  logic [31:0] ir [2];

  logic [1:0]  pcEn, marEn, mdrEn, irEn, yEn, zEn, hiEn, loEn;
  logic [1:0]  pcOut, zHighOut, zLowOut, hiOut, loOut, mdrOut, inPortOut, baOut, cOut;
  logic [1:0]  readS, writeS, incPc, conEn, outPortEn, runS, illS;
  logic [15:0] enIn [2];
  logic [15:0] rOut [2];
  logic [31:0] cExt [2];
  logic [4:0]  opc  [2];

  int checks = 0;
  int bad = 0;

  // Both instances share the clock; only the wait depth differs
  for (genvar g = 0; g < 2; g++) begin : gDut
    control_unit #(.MEM_WAIT(g * 2), .OPC_W(5)) u_dut (
      .clk(clk), .clr(clr[g]), .ir(ir[g]), .con_ff(conFf[g]),
      .R0_15_enable_in(enIn[g]), .R0_15_out_in(rOut[g]),
      .PC_enable(pcEn[g]), .MAR_enable(marEn[g]), .MDR_enable(mdrEn[g]),
      .IR_enable(irEn[g]), .Y_enable(yEn[g]), .Z_enable(zEn[g]),
      .HI_enable(hiEn[g]), .LO_enable(loEn[g]),
      .PCout(pcOut[g]), .ZHighout(zHighOut[g]), .ZLowout(zLowOut[g]),
      .HIout(hiOut[g]), .LOout(loOut[g]), .MDRout(mdrOut[g]),
      .InPortout(inPortOut[g]), .BAout(baOut[g]), .Cout(cOut[g]),
      .Read(readS[g]), .Write(writeS[g]), .IncPC(incPc[g]),
      .CON_enable(conEn[g]), .OutPort_enable(outPortEn[g]),
      .C_sign_extend(cExt[g]), .opcode(opc[g]), .run(runS[g]), .illegal(illS[g])
    );
  end

  localparam logic [21:0] M_PCEN  = 22'h1 << 21, M_MAREN = 22'h1 << 20;
  localparam logic [21:0] M_MDREN = 22'h1 << 19, M_IREN  = 22'h1 << 18;
  localparam logic [21:0] M_YEN   = 22'h1 << 17, M_ZEN   = 22'h1 << 16;
  localparam logic [21:0] M_HIEN  = 22'h1 << 15, M_LOEN  = 22'h1 << 14;
  localparam logic [21:0] M_PCOUT = 22'h1 << 13, M_ZHI   = 22'h1 << 12;
  localparam logic [21:0] M_ZLO   = 22'h1 << 11, M_HIOUT = 22'h1 << 10;
  localparam logic [21:0] M_LOOUT = 22'h1 << 9,  M_MDROUT = 22'h1 << 8;
  localparam logic [21:0] M_INOUT = 22'h1 << 7,  M_BAOUT = 22'h1 << 6;
  localparam logic [21:0] M_COUT  = 22'h1 << 5,  M_READ  = 22'h1 << 4;
  localparam logic [21:0] M_WRITE = 22'h1 << 3,  M_INCPC = 22'h1 << 2;
  localparam logic [21:0] M_CONEN = 22'h1 << 1,  M_OUTEN = 22'h1 << 0;
  localparam logic [21:0] F_T0 = M_PCOUT | M_MAREN | M_INCPC | M_ZEN;
  localparam logic [21:0] F_T1 = M_ZLO | M_PCEN | M_READ | M_MDREN;
  localparam logic [21:0] F_T2 = M_MDROUT | M_IREN;

  localparam logic [31:0] I_ADD  = {5'd3, 4'd3, 4'd1, 4'd2, 15'd0};
  localparam logic [31:0] I_BR   = {5'd18, 4'd2, 4'd0, 19'h00010};
  localparam logic [31:0] I_JAL  = {5'd20, 4'd4, 23'd0};
  localparam logic [31:0] I_NEG  = {5'd16, 4'd1, 4'd2, 19'd0};
  localparam logic [31:0] I_ADDI = {5'd11, 4'd2, 4'd3, 19'h7FFFF};
  localparam logic [31:0] I_ST   = {5'd2, 4'd3, 4'd1, 19'h00010};
  localparam logic [31:0] I_MFHI = {5'd23, 4'd7, 23'd0};
  localparam logic [31:0] I_NOP  = {5'd25, 27'd0};
  localparam logic [31:0] I_BAD  = {5'd30, 27'd0};
  localparam logic [31:0] I_MUL  = {5'd14, 4'd5, 4'd6, 19'd0};
  localparam logic [31:0] I_HALT = {5'd26, 27'd0};
  localparam logic [31:0] I_LD   = {5'd0, 4'd1, 4'd0, 19'h00055};

  function automatic logic [21:0] strobesOf(input int d);
    return {pcEn[d], marEn[d], mdrEn[d], irEn[d], yEn[d], zEn[d], hiEn[d], loEn[d],
            pcOut[d], zHighOut[d], zLowOut[d], hiOut[d], loOut[d], mdrOut[d],
            inPortOut[d], baOut[d], cOut[d], readS[d], writeS[d], incPc[d],
            conEn[d], outPortEn[d]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int d, input logic [31:0] instr,
                               input logic cond, input logic rst);
    ir[d] = instr;
    conFf[d] = cond;
    clr[d] = rst;
    #1;
  endtask

  // Compares every output group of instance d against hand-derived values
  task automatic checkOutput(input string tag, input int d, input logic [21:0] expS,
                             input logic [15:0] expIn, input logic [15:0] expOut,
                             input logic [4:0] expOp, input logic expRun, input logic expIll);
    checks += 6;
    assert (strobesOf(d) === expS) else begin
      bad++; $error("[TB] FAIL %s strobes observed=%h expected=%h", tag, strobesOf(d), expS);
    end
    assert (enIn[d] === expIn) else begin
      bad++; $error("[TB] FAIL %s enable_in observed=%h expected=%h", tag, enIn[d], expIn);
    end
    assert (rOut[d] === expOut) else begin
      bad++; $error("[TB] FAIL %s out_in observed=%h expected=%h", tag, rOut[d], expOut);
    end
    assert (opc[d] === expOp) else begin
      bad++; $error("[TB] FAIL %s opcode observed=%0d expected=%0d", tag, opc[d], expOp);
    end
    assert (runS[d] === expRun) else begin
      bad++; $error("[TB] FAIL %s run observed=%b expected=%b", tag, runS[d], expRun);
    end
    assert (illS[d] === expIll) else begin
      bad++; $error("[TB] FAIL %s illegal observed=%b expected=%b", tag, illS[d], expIll);
    end
  endtask

  task automatic checkCext(input string tag, input int d, input logic [31:0] expC);
    checks++;
    assert (cExt[d] === expC) else begin
      bad++; $error("[TB] FAIL %s C_sign_extend observed=%h expected=%h", tag, cExt[d], expC);
    end
  endtask

  // Fetch T0..T2, with T1 stretched by 'waits' cycles and MDR loading last
  task automatic checkFetch(input string tag, input int d, input int waits);
    checkOutput({tag, ".t0"}, d, F_T0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
    step();
    for (int i = 0; i <= waits; i++) begin
      checkOutput({tag, ".t1"}, d, (i == waits) ? F_T1 : (F_T1 & ~M_MDREN),
                  16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
      step();
    end
    checkOutput({tag, ".t2"}, d, F_T2, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
    step();
  endtask

  task automatic runBr(input string tag, input logic cond);
    applyStimulus(0, I_BR, cond, 1'b0);
    checkFetch(tag, 0, 0);
    checkOutput({tag, ".t3"}, 0, M_CONEN, 16'h0, 16'h0004, 5'd0, 1'b1, 1'b0); step();
    checkOutput({tag, ".t4"}, 0, M_PCOUT | M_YEN, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0); step();
    checkOutput({tag, ".t5"}, 0, M_COUT | M_ZEN, 16'h0, 16'h0, 5'd3, 1'b1, 1'b0); step();
    checkOutput({tag, ".t6"}, 0, cond ? (M_ZLO | M_PCEN) : M_ZLO,
                16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
    step();
  endtask

  initial begin
    applyStimulus(0, I_NOP, 1'b0, 1'b1);
    applyStimulus(1, I_NOP, 1'b0, 1'b1);
    step(); step();
    checkOutput("rst0", 0, 22'h0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
    checkOutput("rst1", 1, 22'h0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);

    $display("[TB] ADD r3,r1,r2");
    applyStimulus(0, I_ADD, 1'b0, 1'b0);
    checkFetch("add", 0, 0);
    checkOutput("add.t3", 0, M_YEN, 16'h0, 16'h0002, 5'd0, 1'b1, 1'b0); step();
    checkOutput("add.t4", 0, M_ZEN, 16'h0, 16'h0004, 5'd3, 1'b1, 1'b0); step();
    checkOutput("add.t5", 0, M_ZLO, 16'h0008, 16'h0, 5'd0, 1'b1, 1'b0); step();

    $display("[TB] BR with con_ff low then high");
    runBr("br0", 1'b0);
    runBr("br1", 1'b1);

    $display("[TB] JAL r4");
    applyStimulus(0, I_JAL, 1'b0, 1'b0);
    checkFetch("jal", 0, 0);
    checkOutput("jal.t3", 0, M_PCOUT, 16'h8000, 16'h0, 5'd0, 1'b1, 1'b0); step();
    checkOutput("jal.t4", 0, M_PCEN, 16'h0, 16'h0010, 5'd0, 1'b1, 1'b0); step();

    $display("[TB] NEG r1,r2");
    applyStimulus(0, I_NEG, 1'b0, 1'b0);
    checkFetch("neg", 0, 0);
    checkOutput("neg.t3", 0, M_ZEN, 16'h0, 16'h0004, 5'd16, 1'b1, 1'b0); step();
    checkOutput("neg.t4", 0, M_ZLO, 16'h0002, 16'h0, 5'd0, 1'b1, 1'b0); step();

    $display("[TB] ADDI r2,r3,-1");
    applyStimulus(0, I_ADDI, 1'b0, 1'b0);
    checkFetch("addi", 0, 0);
    checkOutput("addi.t3", 0, M_YEN, 16'h0, 16'h0008, 5'd0, 1'b1, 1'b0); step();
    checkOutput("addi.t4", 0, M_COUT | M_ZEN, 16'h0, 16'h0, 5'd3, 1'b1, 1'b0);
    checkCext("addi.c", 0, 32'hFFFF_FFFF); step();
    checkOutput("addi.t5", 0, M_ZLO, 16'h0004, 16'h0, 5'd0, 1'b1, 1'b0); step();

    $display("[TB] ST r3,0x10(r1)");
    applyStimulus(0, I_ST, 1'b0, 1'b0);
    checkFetch("st", 0, 0);
    checkOutput("st.t3", 0, M_BAOUT | M_YEN, 16'h0, 16'h0002, 5'd0, 1'b1, 1'b0); step();
    checkOutput("st.t4", 0, M_COUT | M_ZEN, 16'h0, 16'h0, 5'd3, 1'b1, 1'b0);
    checkCext("st.c", 0, 32'h0000_0010); step();
    checkOutput("st.t5", 0, M_ZLO | M_MAREN, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0); step();
    checkOutput("st.t6", 0, M_MDREN, 16'h0, 16'h0008, 5'd0, 1'b1, 1'b0); step();
    checkOutput("st.t7", 0, M_WRITE, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0); step();

    $display("[TB] MFHI r7 and NOP");
    applyStimulus(0, I_MFHI, 1'b0, 1'b0);
    checkFetch("mfhi", 0, 0);
    checkOutput("mfhi.t3", 0, M_HIOUT, 16'h0080, 16'h0, 5'd0, 1'b1, 1'b0); step();
    applyStimulus(0, I_NOP, 1'b0, 1'b0);
    checkFetch("nop", 0, 0);

    $display("[TB] undefined opcode 30");
    applyStimulus(0, I_BAD, 1'b0, 1'b0);
    checkFetch("bad", 0, 0);
    checkOutput("bad.t3", 0, 22'h0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b1); step();
`ifdef CTRL_ILLEGAL_TRAP_EN
    checkOutput("bad.halt", 0, 22'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b1); step();
    checkOutput("bad.sticky", 0, 22'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b1);
    applyStimulus(0, I_BAD, 1'b0, 1'b1);
    step();
    applyStimulus(0, I_BAD, 1'b0, 1'b0);
`endif
    checkOutput("bad.next", 0, F_T0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);

    $display("[TB] MUL r5,r6 abandoned in T4 then rerun");
    applyStimulus(0, I_MUL, 1'b0, 1'b0);
    checkFetch("mul", 0, 0);
    checkOutput("mul.t3", 0, M_YEN, 16'h0, 16'h0020, 5'd0, 1'b1, 1'b0); step();
    checkOutput("mul.t4", 0, M_ZEN, 16'h0, 16'h0040, 5'd14, 1'b1, 1'b0);
    applyStimulus(0, I_MUL, 1'b0, 1'b1);
    checkOutput("mul.clr", 0, 22'h0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
    step();
    applyStimulus(0, I_MUL, 1'b0, 1'b0);
    checkFetch("mul2", 0, 0);
    checkOutput("mul2.t3", 0, M_YEN, 16'h0, 16'h0020, 5'd0, 1'b1, 1'b0); step();
    checkOutput("mul2.t4", 0, M_ZEN, 16'h0, 16'h0040, 5'd14, 1'b1, 1'b0); step();
    checkOutput("mul2.t5", 0, M_ZLO | M_LOEN, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0); step();
    checkOutput("mul2.t6", 0, M_ZHI | M_HIEN, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0); step();

    $display("[TB] HALT then clr");
    applyStimulus(0, I_HALT, 1'b0, 1'b0);
    checkFetch("halt", 0, 0);
    for (int i = 0; i < 20; i++) begin
      checkOutput("halt.idle", 0, 22'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
      step();
    end
    applyStimulus(0, I_ADD, 1'b0, 1'b1);
    step();
    applyStimulus(0, I_ADD, 1'b0, 1'b0);
    checkOutput("halt.clr", 0, F_T0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);

    $display("[TB] LD r1,0x55(r0) with MEM_WAIT=2");
    applyStimulus(1, I_LD, 1'b0, 1'b0);
    checkFetch("ld", 1, 2);
    checkOutput("ld.t3", 1, M_BAOUT | M_YEN, 16'h0, 16'h0001, 5'd0, 1'b1, 1'b0); step();
    checkOutput("ld.t4", 1, M_COUT | M_ZEN, 16'h0, 16'h0, 5'd3, 1'b1, 1'b0);
    checkCext("ld.c", 1, 32'h0000_0055); step();
    checkOutput("ld.t5", 1, M_ZLO | M_MAREN, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0); step();
    for (int i = 0; i < 3; i++) begin
      checkOutput("ld.t6", 1, (i == 2) ? (M_READ | M_MDREN) : M_READ,
                  16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
      step();
    end
    checkOutput("ld.t7", 1, M_MDROUT, 16'h0002, 16'h0, 5'd0, 1'b1, 1'b0); step();
    checkOutput("ld.end", 1, F_T0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end

endmodule
